led_frame_buffer: RTL
=====================

# led_frame_buffer

Double-buffered GRB pixel store that sits directly upstream of `led_driver`. A host (pattern generator or control logic) writes per-LED colours into a back buffer. `led_driver` pulls colours from the front buffer by index. Buffers swap only at a frame boundary, so a strand update never mixes two frames.

## Interface
Parameters:
- `NUM_LEDS`, 20, number of LEDs on the strand; both buffers hold this many 24-bit entries.
- `COUNTER_WIDTH`, `$clog2(NUM_LEDS)`, localparam; index ports are `COUNTER_WIDTH+1` bits wide, matching `led_driver`.

Ports:
- `clk_in` input 1: 100 MHz system clock. One clock domain; reset is synchronous and active-high.
- `rst` input 1: synchronous, active-high reset.
- `wr_en` input 1: host write strobe, one write per cycle.
- `wr_addr` input COUNTER_WIDTH+1: LED index for the write.
- `wr_green`, `wr_red`, `wr_blue` input 8 each: colour to write.
- `swap_req` input 1: single-cycle pulse requesting a swap at the next frame boundary.
- `brightness` input 8: global scale factor; used only when `LED_BRIGHTNESS_EN` is defined.
- `next_led_request` input COUNTER_WIDTH+1: LED index requested by `led_driver`.
- `request_valid` input 1: single-cycle request strobe from `led_driver`.
- `green_out`, `red_out`, `blue_out` output 8 each: colour feeding `led_driver` `green_in`/`red_in`/`blue_in`.
- `color_valid` output 1: single-cycle pulse; colour outputs are valid in this cycle.
- `swap_pending` output 1: a swap has been requested and has not yet occurred.
- `swap_done` output 1: single-cycle pulse in the cycle after a swap takes effect.

## Operation
- Storage is two banks of `NUM_LEDS` x 24 bits, inferred as BRAM/LUTRAM. There is no reset of contents; contents are undefined until written.
- `front_sel` (internal, resets to 0) selects the bank that is read. Writes go to bank `!front_sel` as sampled in the write cycle.
- Write: when `wr_en=1` and `wr_addr < NUM_LEDS`, the entry is written at the clock edge. An out-of-range `wr_addr` is ignored with no side effect.
- Swap request: `swap_req` sets the pending flag. A second request while pending has no additional effect.
- Frame boundary is a cycle with `request_valid=1` and `next_led_request==0`.
  - If the pending flag is set in that cycle, `front_sel` toggles and the pending flag clears.
  - The index-0 read in that cycle, and every read after it, uses the new front bank.
  - `swap_done` pulses one cycle later.
- `swap_req` arriving in the same cycle as a boundary is taken at that boundary.
- Read pipeline:
  - Stage 1 registers the index, the valid bit and the bank select.
  - Stage 2 registers the RAM data and output valid.
  - Requests are accepted every cycle and are never back-pressured.
- Out-of-range request (`next_led_request >= NUM_LEDS`): the response is 0/0/0 with `color_valid=1`.
- A write and a read to the same bank and entry in the same cycle return the old data. This cannot occur for the front bank, since writes only target the back bank.
- Reset mid-operation: all in-flight requests are dropped, no `color_valid` follows, `front_sel` returns to 0 and the pending flag clears.

## Timing
- Reset values: `green_out`/`red_out`/`blue_out`=0, `color_valid`=0, `swap_pending`=0, `swap_done`=0.
- Latency: `request_valid` in cycle N gives `color_valid` in cycle N+2, with the data for the index sampled in N.
- Throughput: one response per cycle. Pipelined requests produce back-to-back responses in request order.
- Colour outputs hold their last value while `color_valid=0`.
- Write-to-read visibility: a write in cycle W is visible to the front bank only after a swap at a boundary in a cycle later than W.
- `swap_pending` goes high the cycle after `swap_req` and low the cycle after the boundary.

## Configuration
- `LED_BRIGHTNESS_EN` defined: each output channel in stage 2 becomes `(c * (brightness + 1)) >> 8`.
  - Compute in 17-bit and truncate to 8 bits.
  - `brightness=255` passes the colour unchanged; `brightness=0` yields `c>>8`, i.e. 0.
  - Latency is unchanged at 2.
- Not defined: the `brightness` port is ignored and the raw stored colour is output.

## Test plan
- Reset, then request index 3 with no writes → `color_valid` at N+2. Outputs after reset and before any request are 0, `swap_pending=0`.
- Write LED 0–2 = (10,20,30), (40,50,60), (70,80,90); pulse `swap_req`; request indices 0,1,2 on consecutive cycles → `swap_done` one cycle after index-0 request; responses (10,20,30), (40,50,60), (70,80,90) on three consecutive cycles starting N+2.
- Without swap: write LED 5 = (255,0,0) to back bank, request 5 → old front value is returned, not (255,0,0). Then swap at index 0 and request 5 → (255,0,0).
- Pulse `swap_req` mid-frame while requesting index 7 → no swap and `swap_pending` stays 1. At the next index-0 request the swap occurs and `swap_pending` drops.
- Request index `NUM_LEDS` (20) → (0,0,0) with `color_valid=1`. Write to address 20 → no entry changes.
- With `LED_BRIGHTNESS_EN`, `brightness=127`, stored (200,100,2) → output (100,50,1). Assert `rst` one cycle after a request → no `color_valid` follows.

Source files
------------

// File: rtl/led_frame_buffer.sv
// led_frame_buffer: double-buffered GRB pixel store feeding led_driver.
// The host writes the back bank, and led_driver reads the front bank by index.
// The banks swap only at a frame boundary (index-0 request), so a strand
// update never mixes two frames.
// Optional feature: define LED_BRIGHTNESS_EN to apply a global brightness
// scale to each output channel in stage 2.
module led_frame_buffer #(
   parameter  int NUM_LEDS      = 20,
   localparam int COUNTER_WIDTH = $clog2(NUM_LEDS)
) (
   input  logic                     clk_in,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [COUNTER_WIDTH:0]   wr_addr,
   input  logic [7:0]               wr_green,
   input  logic [7:0]               wr_red,
   input  logic [7:0]               wr_blue,
   input  logic                     swap_req,
   input  logic [7:0]               brightness,
   input  logic [COUNTER_WIDTH:0]   next_led_request,
   input  logic                     request_valid,
   output logic [7:0]               green_out,
   output logic [7:0]               red_out,
   output logic [7:0]               blue_out,
   output logic                     color_valid,
   output logic                     swap_pending,
   output logic                     swap_done
);

   localparam int IW = COUNTER_WIDTH + 1;

   // Two banks of packed {g,r,b}; no reset so they map onto RAM primitives.
   logic [23:0] bank0 [NUM_LEDS];
   logic [23:0] bank1 [NUM_LEDS];

   logic           front_sel;
   logic           boundary;
   logic           swap_now;
   logic           read_sel;
   logic           wr_ok;
   logic           rd_oor;
   logic [1:0]     vld_pipe;   // [0] stage 1, [1] stage 2 (= color_valid)
   logic           oor_s1;
   logic [23:0]    data_s1;

   // A boundary request with a swap pending (or arriving now) flips the
   // front bank, and that very index-0 read already sees the new front bank.
   assign boundary = request_valid && (next_led_request == '0);
   assign swap_now = boundary && (swap_pending || swap_req);
   assign read_sel = front_sel ^ swap_now;
   assign wr_ok    = wr_en && (wr_addr < IW'(NUM_LEDS));
   assign rd_oor   = next_led_request >= IW'(NUM_LEDS);

`ifdef LED_BRIGHTNESS_EN
   // (c * (b + 1)) >> 8 in 17 bits: b=255 is identity, b=0 gives 0.
   function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
      return 8'((17'(c) * (17'(b) + 17'd1)) >> 8);
   endfunction
`else
   function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
      return c;
   endfunction
   // brightness is deliberately ignored in this build
   logic unused_brightness;
   assign unused_brightness = ^brightness;
`endif

   // Host writes always land in the bank that is currently the back bank.
   always_ff @(posedge clk_in) begin
      if (wr_ok) begin
         if (front_sel)
            bank0[wr_addr[COUNTER_WIDTH-1:0]] <= {wr_green, wr_red, wr_blue};
         else
            bank1[wr_addr[COUNTER_WIDTH-1:0]] <= {wr_green, wr_red, wr_blue};
      end
   end

   // Stage 1 data: synchronous read with the bank select resolved this cycle;
   // a write to the same entry at this edge returns the old data.
   always_ff @(posedge clk_in) begin
      data_s1 <= read_sel ? bank1[next_led_request[COUNTER_WIDTH-1:0]]
                          : bank0[next_led_request[COUNTER_WIDTH-1:0]];
   end

   // Swap control: pending flag, front bank select and the done pulse.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         front_sel    <= 1'b0;
         swap_pending <= 1'b0;
         swap_done    <= 1'b0;
      end else begin
         front_sel    <= read_sel;
         swap_pending <= swap_now ? 1'b0 : (swap_pending | swap_req);
         swap_done    <= swap_now;
      end
   end

   // Stage 1 control: valid bit and out-of-range flag.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         vld_pipe[0] <= 1'b0;
         oor_s1      <= 1'b0;
      end else begin
         vld_pipe[0] <= request_valid;
         oor_s1      <= rd_oor;
      end
   end

   // Stage 2: register the colour (zeroed when out of range); hold otherwise.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         vld_pipe[1] <= 1'b0;
         green_out   <= 8'd0;
         red_out     <= 8'd0;
         blue_out    <= 8'd0;
      end else begin
         vld_pipe[1] <= vld_pipe[0];
         if (vld_pipe[0]) begin
            if (oor_s1) begin
               green_out <= 8'd0;
               red_out   <= 8'd0;
               blue_out  <= 8'd0;
            end else begin
               green_out <= scale(data_s1[23:16], brightness);
               red_out   <= scale(data_s1[15:8],  brightness);
               blue_out  <= scale(data_s1[7:0],   brightness);
            end
         end
      end
   end

   assign color_valid = vld_pipe[1];

endmodule
